cipher_cfg_loader: RTL
======================

CIPHER_CFG_LOADER -- requirements
Module: cipher_cfg_loader

Interface
REQ-001 SHALL have parameter M, default 32, meaning LFSR width of the downstream cipher; CFG_BITS = 4*M+3 (131), NBYTES = ceil(CFG_BITS/8) (17).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_valid  input  1  byte write request.
REQ-005 SHALL have port wr_data  input  8  config byte, LSB-first ordering.
REQ-006 SHALL have port wr_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port start  input  1  single-cycle request to shift staged config out.
REQ-008 SHALL have port busy  output  1  high while shifting.
REQ-009 SHALL have port done  output  1  one-cycle pulse after last bit shifted.
REQ-010 SHALL have port err  output  1  one-cycle pulse when start is rejected.
REQ-011 SHALL have port cfg_en  output  1  drives cipher cfg_en.
REQ-012 SHALL have port cfg_i  output  1  drives cipher cfg_i (serial config data).
REQ-013 SHALL have port cfg_o  input  1  cipher serial readback.
REQ-014 SHALL have port rd_data  output  CFG_BITS  captured previous cipher config.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DONE; IDLE->SHIFT on accepted start, SHIFT->DONE after CFG_BITS shift cycles, DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL assert wr_ready only in IDLE with byte count < NBYTES; handshake = wr_valid & wr_ready.
REQ-017 SHALL write byte n to staging bits [8n+7:8n] on handshake n; bits above CFG_BITS-1 in the last byte are discarded.
REQ-018 SHALL accept start only in IDLE with byte count == NBYTES; any other start (partial load, busy, DONE) is ignored and pulses err the next cycle.
REQ-019 SHALL hold cfg_en high for exactly CFG_BITS consecutive cycles, beginning the cycle after start is accepted.
REQ-020 SHALL drive cfg_i = staging bit k during shift cycle k (k = 0..CFG_BITS-1), bit 0 first, so staging bit k lands at cipher cfg_reg[k].
REQ-021 SHALL hold cfg_i low whenever cfg_en is low.
REQ-022 SHALL, in DONE, pulse done for one cycle, deassert busy, and clear byte count so the next load restarts at byte 0.
REQ-023 busy SHALL equal cfg_en.
REQ-024 SHALL not support aborting a shift other than by rst.

Reset
REQ-025 On rst, SHALL enter IDLE, clear byte count, bit counter and staging, and drive wr_ready=1, busy=0, done=0, err=0, cfg_en=0, cfg_i=0, rd_data=0 the following cycle.
REQ-026 rst asserted mid-shift SHALL drop cfg_en the next cycle; the downstream cipher is reset by the same rst.

Configuration
REQ-027 With CFG_READBACK_EN defined, SHALL sample cfg_o on each shift cycle k into rd_data[k], latching the cipher's prior configuration; rd_data is stable from done onward until the next shift.
REQ-028 Without CFG_READBACK_EN, SHALL ignore cfg_o and tie rd_data to zero.

Structure
REQ-029 SHALL place CFG_BITS/NBYTES derivation functions and the state enum in shared package cipher_pkg.
REQ-030 SHALL be a single module, no sub-modules; the byte and bit counters are local.

Verification
REQ-031 Reset: assert rst 2 cycles -> wr_ready=1, cfg_en=0, cfg_i=0, busy=0, rd_data=0.
REQ-032 Full load: 17 bytes 0x55 then start -> cfg_en high exactly 131 cycles, cfg_i toggles 1,0,1...; done pulses once; cipher cfg_reg = 131'h...5 pattern.
REQ-033 Early start: 16 bytes, then start -> err pulses, cfg_en stays 0, 17th byte still accepted.
REQ-034 Backpressure: wr_valid held high for 20 cycles -> exactly 17 handshakes, wr_ready low thereafter.
REQ-035 Readback (CFG_READBACK_EN): after cipher reset, shift any config -> rd_data[127:0] = {32'h48000000,32'h55,32'h48000000,32'h55}, rd_data[130:128]=0.
REQ-036 Mid-shift reset: rst at shift cycle 60 -> cfg_en=0 next cycle, state IDLE, byte count 0.

Source files
------------

// File: rtl/cipher_pkg.sv
// ---------------------------------------------------------------------------
// cipher_pkg
//
// Shared definitions for the cipher configuration path: the loader state
// enum and the helpers that derive the configuration word width and the
// number of bytes needed to stage it from the cipher LFSR width M.
//
// Contents:
//   state_e   - loader sequencing states (idle / shifting / done)
//   cfgBits   - configuration word width in bits for LFSR width m
//   cfgBytes  - number of whole bytes needed to hold cfgBits(m)
// ---------------------------------------------------------------------------
package cipher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Four LFSR-wide fields plus three control bits make up one config word.
    function automatic int cfgBits(input int m);
        return 4 * m + 3;
    endfunction

    // Bytes are written whole, so round the config width up to a byte.
    function automatic int cfgBytes(input int m);
        return (cfgBits(m) + 7) / 8;
    endfunction

endpackage

// File: rtl/cipher_cfg_loader.sv
// ---------------------------------------------------------------------------
// cipher_cfg_loader
//
// Collects a cipher configuration word one byte at a time (LSB-first) into
// a staging register, then on request shifts it serially into the cipher's
// configuration chain, bit 0 first, with cfg_en held high for exactly one
// cycle per configuration bit.
//
// Optional feature (compile-time macro CFG_READBACK_EN):
//   When defined, the cipher's serial readback cfg_o is sampled on every
//   shift cycle k into rd_data[k], capturing the configuration the cipher
//   held before this load. When undefined, cfg_o is ignored and rd_data
//   is tied to zero.
//
// Parameters:
//   M         - LFSR width of the downstream cipher (default 32)
//   CFG_BITS  - derived configuration width, 4*M+3
//
// Ports:
//   clk       in   single clock, all logic on the rising edge
//   rst       in   synchronous, active-high reset
//   wr_valid  in   byte write request
//   wr_data   in   configuration byte, byte n fills staging bits [8n+7:8n]
//   wr_ready  out  a byte is accepted this cycle when wr_valid is also high
//   start     in   single-cycle request to shift the staged word out
//   busy      out  high while shifting (identical to cfg_en)
//   done      out  one-cycle pulse after the last bit has been shifted
//   err       out  one-cycle pulse the cycle after a rejected start
//   cfg_en    out  cipher configuration shift enable
//   cfg_i     out  cipher serial configuration data
//   cfg_o     in   cipher serial configuration readback
//   rd_data   out  previous cipher configuration captured during the shift
// ---------------------------------------------------------------------------
module cipher_cfg_loader
    import cipher_pkg::*;
#(
    parameter  int M        = 32,
    localparam int CFG_BITS = cfgBits(M)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    input  logic [7:0]          wr_data,
    output logic                wr_ready,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                cfg_en,
    output logic                cfg_i,
    input  logic                cfg_o,
    output logic [CFG_BITS-1:0] rd_data
);

    localparam int NBYTES = cfgBytes(M);
    localparam int BYTE_W = $clog2(NBYTES + 1);
    localparam int BIT_W  = $clog2(CFG_BITS);

    state_e              state_q;
    logic [BYTE_W-1:0]   byteCnt_q;
    logic [BIT_W-1:0]    bitCnt_q;
    logic [BIT_W-1:0]    bitCnt_d;
    logic [CFG_BITS-1:0] staging_q;
    logic [CFG_BITS-1:0] staging_d;
    logic                cfgEn_q;
    logic                cfgBit_q;
    logic                done_q;
    logic                err_q;

    logic                handshake;
    logic                startOk;
    logic                lastBit;

    // Bytes are only taken while idle and before the staging word is full.
    assign wr_ready  = (state_q == ST_IDLE) && (byteCnt_q < BYTE_W'(NBYTES));
    assign handshake = wr_valid && wr_ready;

    // A start is honoured only from idle with every byte staged; everything
    // else is rejected and reported through err.
    assign startOk   = start && (state_q == ST_IDLE) && (byteCnt_q == BYTE_W'(NBYTES));

    assign lastBit   = (bitCnt_q == BIT_W'(CFG_BITS - 1));
    assign bitCnt_d  = bitCnt_q + 1'b1;

    // Staging next value: the byte selected by the byte counter is replaced
    // by wr_data. Bits of the last byte beyond CFG_BITS-1 have no storage,
    // so they simply fall away.
    for (genvar b = 0; b < CFG_BITS; b++) begin : g_stage
        assign staging_d[b] = (byteCnt_q == BYTE_W'(b / 8)) ? wr_data[b % 8]
                                                            : staging_q[b];
    end

    // Loader sequencing. cfg_en and cfg_i are registered so the cipher sees
    // clean, glitch-free signals; cfg_i is preloaded one cycle ahead from the
    // next staging bit so that during shift cycle k it carries staging bit k.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            byteCnt_q <= '0;
            bitCnt_q  <= '0;
            staging_q <= '0;
            cfgEn_q   <= 1'b0;
            cfgBit_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q  <= start && !startOk;
            done_q <= 1'b0;

            if (handshake) begin
                staging_q <= staging_d;
                byteCnt_q <= byteCnt_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (startOk) begin
                        state_q  <= ST_SHIFT;
                        cfgEn_q  <= 1'b1;
                        cfgBit_q <= staging_q[0];
                        bitCnt_q <= '0;
                    end
                end

                ST_SHIFT: begin
                    if (lastBit) begin
                        state_q  <= ST_DONE;
                        cfgEn_q  <= 1'b0;
                        cfgBit_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        bitCnt_q <= bitCnt_d;
                        cfgBit_q <= staging_q[bitCnt_d];
                    end
                end

                ST_DONE: begin
                    // Next load starts again from byte 0.
                    state_q   <= ST_IDLE;
                    byteCnt_q <= '0;
                end

                default: begin
                    state_q  <= ST_IDLE;
                    cfgEn_q  <= 1'b0;
                    cfgBit_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_en = cfgEn_q;
    assign busy   = cfgEn_q;
    assign cfg_i  = cfgBit_q;
    assign done   = done_q;
    assign err    = err_q;

`ifdef CFG_READBACK_EN
    logic [CFG_BITS-1:0] rdData_q;

    // While the new word shifts in, the cipher shifts its old word out on
    // cfg_o; bit k of the old word appears during shift cycle k. rd_data
    // is only touched while shifting, so it holds steady from done onward.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_q <= '0;
        end else if (state_q == ST_SHIFT) begin
            rdData_q[bitCnt_q] <= cfg_o;
        end
    end

    assign rd_data = rdData_q;
`else
    logic unusedCfgO;

    assign unusedCfgO = cfg_o;
    assign rd_data    = '0;
`endif

endmodule
